// File: rtl/debounce_pkg.sv
// Shared constants, event payload and round-robin pick helper for debounce_event_scheduler.
package debounce_pkg;

    localparam int unsigned TICK_BITS_DEF    = 20;
    localparam int unsigned STABLE_TICKS_DEF = 3;
    localparam int unsigned MAX_CH           = 16;

    typedef struct packed {
        logic [3:0] ch;
        logic       rise;
    } ev_t;

    // First set bit of pend strictly after ptr, wrapping over n channels; ptr if none set.
    function automatic logic [3:0] rr_pick(input logic [15:0] pend, input logic [3:0] ptr,
                                           input int unsigned n);
        logic [3:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            idx = (32'(ptr) + k) % n;
            if ((k <= n) && !found && pend[4'(idx)]) begin
                pick  = 4'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/debounce_event_scheduler_db_channel.sv
// One debounce channel: 2-flop synchroniser, tick-qualified stability counter and level FSM.
module db_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sw_raw,
    output logic db,
    output logic edge_stb,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [0:0] ST_LOW  = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;

    logic [1:0]       sync_q;
    logic             s_sync;
    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             edge_nxt, rise_nxt;

    assign s_sync = sync_q[1];
    assign db     = state[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            state    <= ST_LOW;
            cnt      <= '0;
            edge_stb <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], sw_raw};
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            edge_stb <= edge_nxt;
            rise     <= rise_nxt;
        end
    end

    // Level flips only after STABLE_TICKS consecutive disagreeing ticks
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        edge_nxt  = 1'b0;
        rise_nxt  = rise;
        if (s_sync == state[0]) begin
            cnt_nxt = '0;
        end else if (tick) begin
            if ((32'(cnt) + 32'd1) == STABLE_TICKS) begin
                cnt_nxt  = '0;
                edge_nxt = 1'b1;
                case (state)
                    ST_LOW: begin
                        state_nxt = ST_HIGH;
                        rise_nxt  = 1'b1;
                    end
                    default: begin
                        state_nxt = ST_LOW;
                        rise_nxt  = 1'b0;
                    end
                endcase
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/debounce_event_scheduler.sv
// Multi-channel switch debouncer with round-robin press/release event bus.
// Define DEBOUNCE_EXT_TICK_EN to take the sample tick from tick_in instead of the internal counter.
module debounce_event_scheduler
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned TICK_BITS    = TICK_BITS_DEF,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic                                    clk,
    input  logic                                    rst,
`ifdef DEBOUNCE_EXT_TICK_EN
    input  logic                                    tick_in,
`endif
    input  logic [N_CH-1:0]                         sw,
    output logic [N_CH-1:0]                         db,
    output logic                                    ev_valid,
    input  logic                                    ev_ready,
    output logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0]  ev_ch,
    output logic                                    ev_rise,
    output logic [N_CH-1:0]                         ovf,
    input  logic                                    ovf_clr
);

    localparam int unsigned CH_W = $clog2(N_CH > 1 ? N_CH : 2);

    logic            tick;
    logic [N_CH-1:0] edge_stb, edge_rise;
    logic [N_CH-1:0] pend, pend_nxt, pend_rise, pend_rise_nxt, ovf_nxt, clr;
    logic [CH_W-1:0] ptr, gnt;
    logic            load, any_pend, gnt_rise;
    ev_t             ev_q;

`ifdef DEBOUNCE_EXT_TICK_EN
    assign tick = tick_in;
`else
    logic [TICK_BITS-1:0] tick_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tick_cnt <= '0;
        else      tick_cnt <= tick_cnt + TICK_BITS'(1);
    end

    assign tick = &tick_cnt;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        db_channel #(.STABLE_TICKS(STABLE_TICKS)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .sw_raw   (sw[i]),
            .db       (db[i]),
            .edge_stb (edge_stb[i]),
            .rise     (edge_rise[i])
        );
    end

    assign load     = !ev_valid || ev_ready;
    assign any_pend = |pend;
    assign gnt      = CH_W'(rr_pick(16'(pend), 4'(ptr), N_CH));
    assign ev_ch    = CH_W'(ev_q.ch);
    assign ev_rise  = ev_q.rise;

    // Pending store: a fresh edge beats a same-cycle grant clear; overflow set beats ovf_clr
    always_comb begin
        pend_nxt      = pend;
        pend_rise_nxt = pend_rise;
        ovf_nxt       = ovf_clr ? '0 : ovf;
        clr           = '0;
        gnt_rise      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            clr[i] = load && any_pend && (gnt == CH_W'(i));
            if (clr[i]) gnt_rise = pend_rise[i];
            if (edge_stb[i]) begin
                if (pend[i] && !clr[i]) ovf_nxt[i] = 1'b1;
                pend_nxt[i]      = 1'b1;
                pend_rise_nxt[i] = edge_rise[i];
            end else if (clr[i]) begin
                pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend      <= '0;
            pend_rise <= '0;
            ovf       <= '0;
        end else begin
            pend      <= pend_nxt;
            pend_rise <= pend_rise_nxt;
            ovf       <= ovf_nxt;
        end
    end

    // Output register: reload on empty bus or handshake, otherwise hold the payload
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_valid <= 1'b0;
            ev_q     <= '0;
            ptr      <= CH_W'(N_CH - 1);
        end else if (load) begin
            if (any_pend) begin
                ev_valid  <= 1'b1;
                ev_q.ch   <= 4'(gnt);
                ev_q.rise <= gnt_rise;
                ptr       <= gnt;
            end else begin
                ev_valid <= 1'b0;
            end
        end
    end

endmodule
